// File: rtl/datapath_exec_unit.sv
// Datapath execution unit: register file, operand muxes, ALU, status flags.
// Executes one sequencer control word per clock.
module datapath_exec_unit #(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       alu_op,
  input  logic [4:0]       muxA,
  input  logic [4:0]       muxB,
  input  logic [WIDTH-1:0] imm,
  input  logic             imm_control,
  input  logic [NREGS-1:0] regs_en,
  input  logic             buff_en,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic [4:0]       flags,
  output logic             illegal_op,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;

  // flag bit positions within {N,Z,F,L,C}
  localparam int FN = 4;
  localparam int FZ = 3;
  localparam int FF = 2;
  localparam int FL = 1;
  localparam int FC = 0;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] result;
  logic [4:0]       flags_nxt;

  logic op_and, op_or, op_xor;
  logic op_add, op_addu, op_addc;
  logic op_sub, op_subc, op_cmp;
  logic op_mov, op_lsh;

  logic             carry_in;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;
  logic [4:0]       shamt;
  logic [4:0]       rsh;
  logic [WIDTH-1:0] lsh_res;

  assign op_and  = (alu_op == OP_AND);
  assign op_or   = (alu_op == OP_OR);
  assign op_xor  = (alu_op == OP_XOR);
  assign op_add  = (alu_op == OP_ADD);
  assign op_addu = (alu_op == OP_ADDU);
  assign op_addc = (alu_op == OP_ADDC);
  assign op_sub  = (alu_op == OP_SUB);
  assign op_subc = (alu_op == OP_SUBC);
  assign op_cmp  = (alu_op == OP_CMP);
  assign op_mov  = (alu_op == OP_MOV);
  assign op_lsh  = (alu_op == OP_LSH);

  assign illegal_op = ~(op_and | op_or | op_xor |
                        op_add | op_addu | op_addc |
                        op_sub | op_subc | op_cmp |
                        op_mov | op_lsh);

  // operand selection; index 16-31 routes the external bus
  assign a     = muxA[4] ? bus_in : regs[muxA[3:0]];
  assign b_reg = muxB[4] ? bus_in : regs[muxB[3:0]];
  assign b     = imm_control ? imm : b_reg;

  // only the carry-chained ops consume the stored C flag
  assign carry_in = (op_addc | op_subc) & flags[FC];

  assign add_full = {1'b0, a} + {1'b0, b}
                  + {{WIDTH{1'b0}}, carry_in};
  assign sub_full = {1'b0, a} - {1'b0, b}
                  - {{WIDTH{1'b0}}, carry_in};

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) &
                   (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) &
                   (sub_full[WIDTH-1] != a[WIDTH-1]);

  // signed 5-bit shift count; negative means logical right,
  // and -16 shifts everything out
  assign shamt   = b[4:0];
  assign rsh     = ~shamt + 5'd1;
  assign lsh_res = shamt[4] ? (a >> rsh) : (a << shamt[3:0]);

  // ALU result and next-flag selection
  always_comb begin
    result    = '0;
    flags_nxt = flags;
    unique case (1'b1)
      op_and:  result = a & b;
      op_or:   result = a | b;
      op_xor:  result = a ^ b;
      op_add, op_addc: begin
        result        = add_full[WIDTH-1:0];
        flags_nxt[FC] = add_full[WIDTH];
        flags_nxt[FF] = add_ovf;
      end
      op_addu: result = add_full[WIDTH-1:0];
      op_sub, op_subc: begin
        result        = sub_full[WIDTH-1:0];
        flags_nxt[FC] = sub_full[WIDTH];
        flags_nxt[FF] = sub_ovf;
      end
      op_cmp: begin
        result        = '0;
        flags_nxt[FZ] = (a == b);
        flags_nxt[FL] = (a < b);
        flags_nxt[FN] = ($signed(a) < $signed(b));
      end
      op_mov:  result = b;
      op_lsh:  result = lsh_res;
      default: result = '0;
    endcase
  end

  assign bus_out  = buff_en ? result : '0;
  assign dbg_data = regs[dbg_sel];

  // register file write; CMP never writes back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NREGS; n++) regs[n] <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++)
        if (regs_en[n] && !op_cmp) regs[n] <= result;
    end
  end

  // processor-status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags <= 5'b00000;
    else       flags <= flags_nxt;
  end

endmodule

// File: tb/tb_datapath_exec_unit.sv
// Directed bench for datapath_exec_unit.
// Expectations are queued per cycle and checked by a separate monitor.
module tb_datapath_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  alu_op;
  logic [4:0]  muxA, muxB;
  logic [15:0] imm;
  logic        imm_control;
  logic [15:0] regs_en;
  logic        buff_en;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic [4:0]  flags;
  logic        illegal_op;
  logic [3:0]  dbg_sel;
  logic [15:0] dbg_data;

  datapath_exec_unit dut (
    .clk(clk), .reset(reset), .alu_op(alu_op),
    .muxA(muxA), .muxB(muxB), .imm(imm),
    .imm_control(imm_control), .regs_en(regs_en),
    .buff_en(buff_en), .bus_in(bus_in),
    .bus_out(bus_out), .flags(flags),
    .illegal_op(illegal_op), .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] AND_ = 8'h01, OR_ = 8'h02, XOR_ = 8'h03;
  localparam logic [7:0] ADD = 8'h05, ADDU = 8'h06, ADDC = 8'h07;
  localparam logic [7:0] SUB = 8'h09, SUBC = 8'h0A, CMP = 8'h0B;
  localparam logic [7:0] MOV = 8'h0D, LSH = 8'h84;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] bus;
    logic [4:0]  flg;
    logic        ill;
    logic [15:0] dbg;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  event sample_ev;

  always @(posedge clk) cyc++;

  function automatic void compare(exp_t e);
    tests++;
    if (bus_out !== e.bus) begin
      fails++;
      $display("FAIL %s bus_out got %h expected %h", e.name, bus_out, e.bus);
    end
    tests++;
    if (flags !== e.flg) begin
      fails++;
      $display("FAIL %s flags got %b expected %b", e.name, flags, e.flg);
    end
    tests++;
    if (illegal_op !== e.ill) begin
      fails++;
      $display("FAIL %s illegal_op got %b expected %b",
               e.name, illegal_op, e.ill);
    end
    tests++;
    if (dbg_data !== e.dbg) begin
      fails++;
      $display("FAIL %s dbg_data got %h expected %h", e.name, dbg_data, e.dbg);
    end
  endfunction

  // cycle monitor: check everything queued for this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc != -1 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s missed sample cycle %0d now %0d", e.name, e.cyc, cyc);
      end else begin
        compare(e);
      end
    end
  end

  // between-edge monitor for asynchronous events
  always begin
    @(sample_ev);
    while (q.size() > 0 && q[0].cyc == -1) begin
      exp_t e;
      e = q.pop_front();
      compare(e);
    end
  end

  task automatic drive(input logic [7:0] op, input logic [4:0] ma,
                       input logic [4:0] mb, input logic [15:0] im,
                       input logic ic, input logic [15:0] en,
                       input logic bf, input logic [15:0] bi,
                       input logic [3:0] ds);
    alu_op = op; muxA = ma; muxB = mb; imm = im;
    imm_control = ic; regs_en = en; buff_en = bf;
    bus_in = bi; dbg_sel = ds;
  endtask

  task automatic step(input string nm, input logic [7:0] op,
                      input logic [4:0] ma, input logic [4:0] mb,
                      input logic [15:0] im, input logic ic,
                      input logic [15:0] en, input logic bf,
                      input logic [15:0] bi, input logic [3:0] ds,
                      input logic [15:0] ebus, input logic [4:0] ef,
                      input logic ei, input logic [15:0] ed);
    exp_t e;
    @(posedge clk);
    #1;
    drive(op, ma, mb, im, ic, en, bf, bi, ds);
    e.cyc = cyc; e.name = nm; e.bus = ebus;
    e.flg = ef; e.ill = ei; e.dbg = ed;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    drive(8'h00, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 4'd0);
    //   name      op    mA  mB   imm   ic en     bf bus_in ds  ebus   flg  ill dbg
    step("rst0",  8'h00, 0,  0,  16'h0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 5'h00, 1, 16'h0);
    step("rst1",  ADD,   0,  0,  16'h5, 1, 16'hFFFF, 1, 16'h0, 0, 16'h5, 5'h00, 0, 16'h0);
    @(negedge clk); #1;
    drive(8'h00, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 4'd0);
    reset = 1'b0;
    step("fib1",  ADD,   1,  0,  16'h1, 1, 16'h0002, 1, 16'h0, 1, 16'h0001, 5'h00, 0, 16'h0000);
    step("fib2",  ADD,   1,  2,  16'h0, 0, 16'h0004, 0, 16'h0, 1, 16'h0000, 5'h00, 0, 16'h0001);
    step("fib3",  ADD,   1,  2,  16'h0, 0, 16'h0008, 1, 16'h0, 2, 16'h0002, 5'h00, 0, 16'h0001);
    step("fib4",  ADD,   2,  3,  16'h0, 0, 16'h0010, 1, 16'h0, 3, 16'h0003, 5'h00, 0, 16'h0002);
    step("fib5",  ADD,   3,  4,  16'h0, 0, 16'h0020, 1, 16'h0, 4, 16'h0005, 5'h00, 0, 16'h0003);
    step("fib6",  ADD,   4,  5,  16'h0, 0, 16'h0040, 1, 16'h0, 5, 16'h0008, 5'h00, 0, 16'h0005);
    step("movbus",MOV,   0, 16,  16'h0, 0, 16'h0002, 1, 16'hFFFF, 6, 16'hFFFF, 5'h00, 0, 16'h0008);
    step("addcy", ADD,   1,  0,  16'h1, 1, 16'h0004, 1, 16'h0, 1, 16'h0000, 5'h00, 0, 16'hFFFF);
    step("mov7f", MOV,   0,  0,  16'h7FFF, 1, 16'h0002, 1, 16'h0, 2, 16'h7FFF, 5'h01, 0, 16'h0000);
    step("addc",  ADDC,  0,  0,  16'h0, 1, 16'h0008, 1, 16'h0, 1, 16'h0001, 5'h01, 0, 16'h7FFF);
    step("addov", ADD,   1,  0,  16'h1, 1, 16'h0010, 1, 16'h0, 3, 16'h8000, 5'h00, 0, 16'h0001);
    step("mov3",  MOV,   0,  0,  16'h3, 1, 16'h0002, 1, 16'h0, 4, 16'h0003, 5'h04, 0, 16'h8000);
    step("mov5",  MOV,   0,  0,  16'h5, 1, 16'h0004, 1, 16'h0, 1, 16'h0005, 5'h04, 0, 16'h0003);
    step("sub",   SUB,   1,  2,  16'h0, 0, 16'h0008, 1, 16'h0, 2, 16'hFFFE, 5'h04, 0, 16'h0005);
    step("cmpeq", CMP,   2,  0,  16'h5, 1, 16'hFFFF, 1, 16'h0, 3, 16'h0000, 5'h01, 0, 16'hFFFE);
    step("cmpneg",CMP,  16,  0,  16'h1, 1, 16'hFFFF, 1, 16'hFFFF, 2, 16'h0000, 5'h09, 0, 16'h0005);
    step("lsh4",  LSH,  16,  0,  16'h4, 1, 16'h0020, 1, 16'h0001, 3, 16'h0010, 5'h11, 0, 16'hFFFE);
    step("lshm4", LSH,  16,  0,  16'h001C, 1, 16'h0040, 1, 16'h8000, 5, 16'h0800, 5'h11, 0, 16'h0010);
    step("lshm16",LSH,   5,  0,  16'h0010, 1, 16'h0080, 1, 16'h0, 6, 16'h0000, 5'h11, 0, 16'h0800);
    step("lshm1", LSH,   6,  0,  16'h001F, 1, 16'h0000, 1, 16'h0, 7, 16'h0400, 5'h11, 0, 16'h0000);
    step("ill0",  8'h00, 6,  0,  16'h0, 0, 16'h0000, 1, 16'h0, 3, 16'h0000, 5'h11, 1, 16'hFFFE);
    step("ill0w", 8'h00, 6,  0,  16'h0, 0, 16'h0008, 1, 16'h0, 3, 16'h0000, 5'h11, 1, 16'hFFFE);
    step("ill4",  8'h04, 6,  0,  16'h0, 0, 16'h0000, 1, 16'h0, 3, 16'h0000, 5'h11, 1, 16'h0000);
    step("xor",   XOR_, 16,  0,  16'hFF00, 1, 16'h0002, 1, 16'hF0F0, 0, 16'h0FF0, 5'h11, 0, 16'h0000);
    step("and",   AND_,  1,  0,  16'h00FF, 1, 16'h0004, 1, 16'h0, 1, 16'h00F0, 5'h11, 0, 16'h0FF0);
    step("or",    OR_,   2,  0,  16'h0F00, 1, 16'h0000, 1, 16'h0, 2, 16'h0FF0, 5'h11, 0, 16'h00F0);
    step("addu",  ADDU,  2,  2,  16'h0, 0, 16'h0006, 1, 16'h0, 2, 16'h01E0, 5'h11, 0, 16'h00F0);
    step("subc",  SUBC,  1,  0,  16'h00E0, 1, 16'h0100, 1, 16'h0, 2, 16'h00FF, 5'h11, 0, 16'h01E0);
    step("addc0", ADDC, 16,  0,  16'h0001, 1, 16'h0000, 1, 16'hFFFF, 8, 16'h0000, 5'h10, 0, 16'h00FF);
    step("mov12", MOV,   0,  0,  16'h1234, 1, 16'h0020, 1, 16'h0, 1, 16'h1234, 5'h11, 0, 16'h01E0);
    step("pend",  ADD,   5,  0,  16'h0001, 1, 16'h0020, 1, 16'h0, 5, 16'h1235, 5'h11, 0, 16'h1234);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    e.cyc = -1; e.name = "arst"; e.bus = 16'h0001;
    e.flg = 5'h00; e.ill = 1'b0; e.dbg = 16'h0000;
    q.push_back(e);
    ->sample_ev;
    #1;
    reset = 1'b0;
    step("post",  MOV,   0,  0,  16'h0, 1, 16'h0000, 1, 16'h0, 5, 16'h0000, 5'h00, 0, 16'h0001);
    step("idle",  8'h00, 0,  0,  16'h0, 0, 16'h0000, 0, 16'h0, 5, 16'h0000, 5'h00, 1, 16'h0001);
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
